// File: rtl/jam_cost_table_if.sv
// jam_cost_table_if
// Upstream cost-entry stream into the cost table.
//   in_valid : producer has a cost entry on in_data
//   in_ready : table accepts an entry this cycle
//   in_data  : cost entry (CW bits), worker-major / job-minor order
// Modports: master = entry producer, slave = cost table.
interface jam_cost_table_if #(
    parameter int CW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/jam_cost_table.sv
// jam_cost_table
// Holds an 8x8 worker/job cost matrix for a downstream assignment search.
// The matrix is streamed in row-major order.  While it loads, the search
// engine is held in reset.  After the 64th entry the table switches to
// serving random-access lookups.  A running checksum and a lower bound
// (sum of per-worker row minima) are built up during the load.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   in_if       : entry stream (in_valid / in_ready / in_data), slave side
//   reload      : discard the table and restart loading
//   W, J        : worker / job lookup index
//   Cost        : mem[{W,J}] while serving, 0 while loading
//   jam_rst     : hold for the search engine, high while loading
//   checksum    : sum of all loaded entries
//   lower_bound : sum of the row minima
module jam_cost_table #(
    parameter int CW = 7
) (
    input  logic                CLK,
    input  logic                RST_N,
    jam_cost_table_if.slave     in_if,
    input  logic                reload,
    input  logic [2:0]          W,
    input  logic [2:0]          J,
    output logic [CW-1:0]       Cost,
    output logic                jam_rst,
    output logic [12:0]         checksum,
    output logic [9:0]          lower_bound
);

    typedef enum logic {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [5:0]    cnt_r;
    logic [12:0]   checksum_r;
    logic [9:0]    lower_bound_r;
    logic [CW-1:0] row_min_r;
    logic [CW-1:0] mem_r [64];

    logic          accept_s;
    logic          write_s;
    logic [CW-1:0] min_s;
    logic [CW-1:0] row_min_nxt_s;

    // Handshake: ready only while loading; reload cancels any accept.
    assign in_if.in_ready = (state_r == LOAD);
    assign accept_s       = in_if.in_valid & in_if.in_ready;
    assign write_s        = accept_s & ~reload;

    // jam_rst comes straight from the state flop so it cannot glitch.
    assign jam_rst     = (state_r == LOAD);
    assign checksum    = checksum_r;
    assign lower_bound = lower_bound_r;

    // Row-minimum update: the first job of a row restarts the minimum.
    always_comb begin
        min_s         = (in_if.in_data < row_min_r) ? in_if.in_data : row_min_r;
        row_min_nxt_s = row_min_r;
        if (cnt_r[2:0] == 3'd0) begin
            row_min_nxt_s = in_if.in_data;
        end else begin
            row_min_nxt_s = min_s;
        end
    end

    // Next-state decode; reload always wins over the final accept.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (reload) begin
                    state_nxt_s = LOAD;
                end else if (accept_s && (cnt_r == 6'd63)) begin
                    state_nxt_s = SERVE;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            SERVE: begin
                if (reload) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load counter and running statistics; cleared by reload.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r         <= 6'd0;
            checksum_r    <= 13'd0;
            lower_bound_r <= 10'd0;
            row_min_r     <= {CW{1'b0}};
        end else if (reload) begin
            cnt_r         <= 6'd0;
            checksum_r    <= 13'd0;
            lower_bound_r <= 10'd0;
            row_min_r     <= {CW{1'b0}};
        end else if (write_s) begin
            // Counter wraps to 0 on the 64th entry.
            cnt_r      <= cnt_r + 6'd1;
            checksum_r <= checksum_r + {{(13-CW){1'b0}}, in_if.in_data};
            row_min_r  <= row_min_nxt_s;
            if (cnt_r[2:0] == 3'd7) begin
                lower_bound_r <= lower_bound_r + {{(10-CW){1'b0}}, min_s};
            end else begin
                lower_bound_r <= lower_bound_r;
            end
        end else begin
            cnt_r         <= cnt_r;
            checksum_r    <= checksum_r;
            lower_bound_r <= lower_bound_r;
            row_min_r     <= row_min_r;
        end
    end

    // Cost storage; contents are fully rewritten by every load.
    always_ff @(posedge CLK) begin
        if (write_s) begin
            mem_r[cnt_r] <= in_if.in_data;
        end else begin
            mem_r[cnt_r] <= mem_r[cnt_r];
        end
    end

    // Lookup is combinational and forced to zero while loading.
    always_comb begin
        Cost = {CW{1'b0}};
        if (state_r == SERVE) begin
            Cost = mem_r[{W, J}];
        end else begin
            Cost = {CW{1'b0}};
        end
    end

endmodule
